// File: rtl/axi_slave_mem_if.sv
// Bus bundle between an AXI-style master and the slave memory: AW, W, AR and R
// channels plus the WLAST mismatch pulse and the FSM state debug taps.
interface axi_slave_mem_if #(
    parameter int ADD_SIZE   = 32,
    parameter int DATA_SIZE  = 32,
    parameter int LEN_SIZE   = 4,
    parameter int S_SIZE     = 3,
    parameter int BURST_SIZE = 2
);
    // Write address channel
    logic [ADD_SIZE-1:0]   AWADDR;
    logic [LEN_SIZE-1:0]   AWLEN;
    logic [S_SIZE-1:0]     AWSIZE;
    logic [BURST_SIZE-1:0] AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    // Write data channel
    logic [DATA_SIZE-1:0]  WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    // Read address channel
    logic [ADD_SIZE-1:0]   ARADDR;
    logic [LEN_SIZE-1:0]   ARLEN;
    logic [S_SIZE-1:0]     ARSIZE;
    logic [BURST_SIZE-1:0] ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    // Read data channel
    logic [DATA_SIZE-1:0]  RDATA;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    // Protocol error pulse
    logic                  WLAST_ERR;
    // FSM state taps (0 = IDLE, 1 = DATA)
    logic                  wr_state;
    logic                  rd_state;

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WLAST, WVALID,
        output WREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RLAST, RVALID,
        input  RREADY,
        output WLAST_ERR, wr_state, rd_state
    );

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WLAST, WVALID,
        input  WREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RLAST, RVALID,
        output RREADY,
        input  WLAST_ERR, wr_state, rd_state
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI-style slave memory: terminates AW/W and AR/R with two independent FSMs
// over a word-addressed register array. No B channel, no IDs.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both 1; the sender holds its payload stable while
// VALID=1 and READY=0, and READY may not be used to gate VALID.
module axi_slave_mem #(
    parameter int ADD_SIZE   = 32,
    parameter int DATA_SIZE  = 32,
    parameter int LEN_SIZE   = 4,
    parameter int S_SIZE     = 3,
    parameter int BURST_SIZE = 2,
    parameter int MEM_DEPTH  = 256
) (
    input logic            ACLK,
    input logic            ARESET,
    axi_slave_mem_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_DATA = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

    // Write path state
    logic [0:0]            w_state;
    logic [ADD_SIZE-1:0]   w_addr;
    logic [LEN_SIZE-1:0]   w_len;
    logic [LEN_SIZE-1:0]   w_cnt;
    logic [S_SIZE-1:0]     w_size;
    logic [BURST_SIZE-1:0] w_burst;
    logic                  aw_ready;
    logic                  w_ready;
    logic                  wlast_err;

    // Read path state; r_addr is the address of the next beat to load
    logic [0:0]            r_state;
    logic [ADD_SIZE-1:0]   r_addr;
    logic [LEN_SIZE-1:0]   r_len;
    logic [LEN_SIZE-1:0]   r_cnt;
    logic [S_SIZE-1:0]     r_size;
    logic [BURST_SIZE-1:0] r_burst;
    logic                  ar_ready;
    logic                  r_valid;
    logic                  r_last;
    logic [DATA_SIZE-1:0]  r_data;

    logic aw_fire, w_fire, w_final;
    logic ar_fire, r_fire, r_final;

    assign aw_fire = bus.AWVALID & aw_ready;
    assign w_fire  = bus.WVALID & w_ready;
    assign w_final = (w_cnt == w_len);
    assign ar_fire = bus.ARVALID & ar_ready;
    assign r_fire  = r_valid & bus.RREADY;
    assign r_final = (r_cnt == r_len);

    // Word index: byte address / 4, modulo the memory depth
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADD_SIZE-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    // Address of the beat after addr. Sizes above a word are clamped to a word;
    // WRAP with an illegal length degrades to INCR, reserved type 3 is INCR.
    function automatic logic [ADD_SIZE-1:0] next_addr(
        input logic [ADD_SIZE-1:0]   addr,
        input logic [LEN_SIZE-1:0]   len,
        input logic [S_SIZE-1:0]     size,
        input logic [BURST_SIZE-1:0] burst
    );
        logic [1:0]          eff;
        logic [ADD_SIZE-1:0] step;
        logic [ADD_SIZE-1:0] incr;
        logic [ADD_SIZE-1:0] wrap_mask;
        logic                wrap_ok;
        eff       = (size > S_SIZE'(2)) ? 2'd2 : size[1:0];
        step      = ADD_SIZE'(1) << eff;
        incr      = addr + step;
        wrap_mask = ((ADD_SIZE'(len) + ADD_SIZE'(1)) << eff) - ADD_SIZE'(1);
        wrap_ok   = (len == LEN_SIZE'(1)) || (len == LEN_SIZE'(3)) ||
                    (len == LEN_SIZE'(7)) || (len == LEN_SIZE'(15));
        if (burst == BURST_SIZE'(0)) begin
            return addr;
        end else if (burst == BURST_SIZE'(2) && wrap_ok) begin
            return (addr & ~wrap_mask) | (incr & wrap_mask);
        end else begin
            return incr;
        end
    endfunction

    // Memory write port: one full word per accepted W beat, never during reset
    always_ff @(posedge ACLK) begin
        if (!ARESET && w_fire) begin
            mem[word_idx(w_addr)] <= bus.WDATA;
        end
    end

    // Write FSM: accept an AW, then take LEN+1 W beats; flag WLAST disagreement
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            w_addr    <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_size    <= '0;
            w_burst   <= '0;
            aw_ready  <= 1'b0;
            w_ready   <= 1'b0;
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        w_addr   <= bus.AWADDR;
                        w_len    <= bus.AWLEN;
                        w_size   <= bus.AWSIZE;
                        w_burst  <= bus.AWBURST;
                        w_cnt    <= '0;
                        aw_ready <= 1'b0;
                        w_ready  <= 1'b1;
                        w_state  <= W_DATA;
                    end else begin
                        aw_ready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        // Burst length follows AWLEN regardless of WLAST
                        wlast_err <= bus.WLAST ^ w_final;
                        w_addr    <= next_addr(w_addr, w_len, w_size, w_burst);
                        w_cnt     <= w_cnt + 1'b1;
                        if (w_final) begin
                            w_ready  <= 1'b0;
                            aw_ready <= 1'b1;
                            w_state  <= W_IDLE;
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: first beat loads on the AR handshake, then one load per R transfer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= R_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        // Same-edge write to this word is not visible: old data is returned
                        r_data   <= mem[word_idx(bus.ARADDR)];
                        r_addr   <= next_addr(bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST);
                        r_len    <= bus.ARLEN;
                        r_size   <= bus.ARSIZE;
                        r_burst  <= bus.ARBURST;
                        r_cnt    <= '0;
                        r_valid  <= 1'b1;
                        r_last   <= (bus.ARLEN == '0);
                        ar_ready <= 1'b0;
                        r_state  <= R_DATA;
                    end else begin
                        ar_ready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (r_final) begin
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                            ar_ready <= 1'b1;
                            r_state  <= R_IDLE;
                        end else begin
                            r_data <= mem[word_idx(r_addr)];
                            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                            r_cnt  <= r_cnt + 1'b1;
                            r_last <= (LEN_SIZE'(r_cnt + 1'b1) == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.AWREADY   = aw_ready;
    assign bus.WREADY    = w_ready;
    assign bus.WLAST_ERR = wlast_err;
    assign bus.ARREADY   = ar_ready;
    assign bus.RVALID    = r_valid;
    assign bus.RLAST     = r_last;
    assign bus.RDATA     = r_data;
    assign bus.wr_state  = w_state[0];
    assign bus.rd_state  = r_state[0];
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: table of read bursts over a known image,
// plus hand sequences for backpressure, WLAST errors, collision and reset.
module tb_axi_slave_mem;
    logic ACLK = 1'b0;
    logic ARESET;

    axi_slave_mem_if bus ();

    axi_slave_mem dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    // Clock: 10 ns period; inputs change and outputs are sampled on the falling edge
    always #5 ACLK = ~ACLK;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] wbuf[16];

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0][7:0] widx;
    } rvec_t;

    rvec_t vecs[10];

    function automatic rvec_t mkv(input logic [31:0] addr, input int len, input logic [2:0] size,
                                  input logic [1:0] burst, input int i0, input int i1,
                                  input int i2, input int i3);
        rvec_t v;
        v.addr    = addr;
        v.len     = len;
        v.size    = size;
        v.burst   = burst;
        v.widx[0] = 8'(i0);
        v.widx[1] = 8'(i1);
        v.widx[2] = 8'(i2);
        v.widx[3] = 8'(i3);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic idle_inputs();
        bus.AWADDR  = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA   = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
        bus.ARADDR  = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, 32'(bus.AWREADY), 0);
        chk({tag, "_wready"}, 32'(bus.WREADY), 0);
        chk({tag, "_arready"}, 32'(bus.ARREADY), 0);
        chk({tag, "_rvalid"}, 32'(bus.RVALID), 0);
        chk({tag, "_rlast"}, 32'(bus.RLAST), 0);
        chk({tag, "_rdata"}, bus.RDATA, 0);
        chk({tag, "_wlast_err"}, 32'(bus.WLAST_ERR), 0);
    endtask

    task automatic wait_aw();
        int n = 0;
        while (bus.AWREADY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("aw_ready_timeout", 32'(bus.AWREADY), 1);
    endtask

    task automatic wait_ar();
        int n = 0;
        while (bus.ARREADY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ar_ready_timeout", 32'(bus.ARREADY), 1);
    endtask

    // Driver: AW handshake then len+1 beats from wbuf; WLAST inverted on beat 'flip'
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                               input logic [1:0] burst, input int flip, output int errs);
        errs = 0;
        wait_aw();
        bus.AWADDR  = addr;
        bus.AWLEN   = 4'(len);
        bus.AWSIZE  = size;
        bus.AWBURST = burst;
        bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            chk("w_ready", 32'(bus.WREADY), 1);
            chk("aw_ready_busy", 32'(bus.AWREADY), 0);
            bus.WDATA  = wbuf[b];
            bus.WLAST  = ((b == len) != (b == flip));
            bus.WVALID = 1'b1;
            tick();
            if (bus.WLAST_ERR === 1'b1) errs++;
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        chk("aw_ready_return", 32'(bus.AWREADY), 1);
        chk("w_ready_drop", 32'(bus.WREADY), 0);
        tick();
        if (bus.WLAST_ERR === 1'b1) errs++;
    endtask

    // Driver + scoreboard drain: mode 0 holds RREADY high, mode 1 toggles 1,0,1,0
    task automatic read_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                              input logic [1:0] burst, input int mode);
        int  k = 0;
        logic rr;
        wait_ar();
        bus.ARADDR  = addr;
        bus.ARLEN   = 4'(len);
        bus.ARSIZE  = size;
        bus.ARBURST = burst;
        bus.ARVALID = 1'b1;
        bus.RREADY  = 1'b0;
        tick();
        bus.ARVALID = 1'b0;
        chk("r_latency", 32'(bus.RVALID), 1);
        while (exp_q.size() > 0 && k < 64) begin
            rr = (mode == 0) ? 1'b1 : ((k % 2) == 0);
            chk("r_valid", 32'(bus.RVALID), 1);
            chk("r_data", bus.RDATA, exp_q[0]);
            chk("r_last", 32'(bus.RLAST), 32'(exp_q.size() == 1));
            bus.RREADY = rr;
            tick();
            if (rr) void'(exp_q.pop_front());
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("r_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        bus.RREADY = 1'b0;
        chk("r_valid_end", 32'(bus.RVALID), 0);
        chk("ar_ready_end", 32'(bus.ARREADY), 1);
    endtask

    initial begin
        int errs;

        // Read bursts over the image word[i] = 0xC0DE0000 + i at 0x00..0x3C
        vecs[0] = mkv(32'h08, 3, 3'd2, 2'd2, 2, 3, 0, 1);     // WRAP 4 words
        vecs[1] = mkv(32'h04, 2, 3'd2, 2'd0, 1, 1, 1, 0);     // FIXED
        vecs[2] = mkv(32'h30, 3, 3'd2, 2'd1, 12, 13, 14, 15); // INCR
        vecs[3] = mkv(32'h34, 1, 3'd2, 2'd2, 13, 12, 0, 0);   // WRAP 2 words
        vecs[4] = mkv(32'h00, 3, 3'd1, 2'd1, 0, 0, 1, 1);     // INCR halfword step
        vecs[5] = mkv(32'h08, 2, 3'd2, 2'd2, 2, 3, 4, 0);     // illegal WRAP len -> INCR
        vecs[6] = mkv(32'h20, 1, 3'd5, 2'd1, 8, 9, 0, 0);     // oversize clamps to word
        vecs[7] = mkv(32'h10, 1, 3'd2, 2'd3, 4, 5, 0, 0);     // reserved type -> INCR
        vecs[8] = mkv(32'h06, 3, 3'd1, 2'd2, 1, 0, 0, 1);     // WRAP halfword, 8-byte window
        vecs[9] = mkv(32'h404, 0, 3'd2, 2'd1, 1, 0, 0, 0);    // index wraps mod depth

        idle_inputs();
        ARESET = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        ARESET = 1'b0;
        tick();
        chk("post_reset_awready", 32'(bus.AWREADY), 1);
        chk("post_reset_arready", 32'(bus.ARREADY), 1);

        // Single write then single read
        wbuf[0] = 32'hDEADBEEF;
        write_burst(32'h10, 0, 3'd2, 2'd1, -1, errs);
        chk("single_wlast_err", 32'(errs), 0);
        exp_q.push_back(32'hDEADBEEF);
        read_burst(32'h10, 0, 3'd2, 2'd1, 0);

        // INCR burst with RREADY backpressure
        for (int i = 0; i < 4; i++) wbuf[i] = {4{8'hA0 + 8'(i)}};
        write_burst(32'h100, 3, 3'd2, 2'd1, -1, errs);
        for (int i = 0; i < 4; i++) exp_q.push_back({4{8'hA0 + 8'(i)}});
        read_burst(32'h100, 3, 3'd2, 2'd1, 1);

        // Fill image and run the table
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
        write_burst(32'h00, 15, 3'd2, 2'd1, -1, errs);
        chk("fill_wlast_err", 32'(errs), 0);
        for (int v = 0; v < 10; v++) begin
            for (int b = 0; b <= vecs[v].len; b++) exp_q.push_back(32'hC0DE0000 + 32'(vecs[v].widx[b]));
            read_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0);
        end

        // WLAST early on beat 1 of a 4-beat burst: one pulse, all 4 beats land
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h5A5A0000 + 32'(i);
        write_burst(32'h200, 3, 3'd2, 2'd1, 1, errs);
        chk("wlast_early_pulses", 32'(errs), 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h5A5A0000 + 32'(i));
        read_burst(32'h200, 3, 3'd2, 2'd1, 0);

        // WLAST missing on the final beat of a 2-beat burst
        wbuf[0] = 32'h77770000;
        wbuf[1] = 32'h77770001;
        write_burst(32'h220, 1, 3'd2, 2'd1, 1, errs);
        chk("wlast_missing_pulses", 32'(errs), 1);

        // Simultaneous AW and AR on 0x20: read sees the old word
        wbuf[0] = 32'h11111111;
        write_burst(32'h20, 0, 3'd2, 2'd1, -1, errs);
        wait_aw();
        wait_ar();
        bus.AWADDR = 32'h20; bus.AWLEN = 4'd0; bus.AWSIZE = 3'd2; bus.AWBURST = 2'd1; bus.AWVALID = 1'b1;
        bus.ARADDR = 32'h20; bus.ARLEN = 4'd0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'd1; bus.ARVALID = 1'b1;
        bus.RREADY = 1'b0;
        tick();
        bus.AWVALID = 1'b0;
        bus.ARVALID = 1'b0;
        chk("conc_awready", 32'(bus.AWREADY), 0);
        chk("conc_arready", 32'(bus.ARREADY), 0);
        chk("conc_wready", 32'(bus.WREADY), 1);
        chk("conc_rvalid", 32'(bus.RVALID), 1);
        chk("conc_rdata_old", bus.RDATA, 32'h11111111);
        bus.WDATA = 32'h22222222; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
        bus.RREADY = 1'b1;
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.RREADY = 1'b0;
        chk("conc_rvalid_end", 32'(bus.RVALID), 0);
        chk("conc_wlast_err", 32'(bus.WLAST_ERR), 0);
        exp_q.push_back(32'h22222222);
        read_burst(32'h20, 0, 3'd2, 2'd1, 0);

        // True collision: W commit and first RDATA load of 0x24 on the same edge
        wait_aw();
        bus.AWADDR = 32'h24; bus.AWLEN = 4'd0; bus.AWSIZE = 3'd2; bus.AWBURST = 2'd1; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        wait_ar();
        bus.WDATA = 32'h44444444; bus.WLAST = 1'b1; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h24; bus.ARLEN = 4'd0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'd1; bus.ARVALID = 1'b1;
        bus.RREADY = 1'b0;
        tick();
        bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.ARVALID = 1'b0;
        chk("coll_rvalid", 32'(bus.RVALID), 1);
        chk("coll_rdata_old", bus.RDATA, 32'hC0DE0009);
        chk("coll_rlast", 32'(bus.RLAST), 1);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        exp_q.push_back(32'h44444444);
        read_burst(32'h24, 0, 3'd2, 2'd1, 0);

        // Reset on beat 2 of an 8-beat read
        wait_ar();
        bus.ARADDR = 32'h00; bus.ARLEN = 4'd7; bus.ARSIZE = 3'd2; bus.ARBURST = 2'd1; bus.ARVALID = 1'b1;
        tick();
        bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;
        tick();
        tick();
        chk("rst_rd_beat2", bus.RDATA, 32'hC0DE0002);
        ARESET = 1'b1;
        tick();
        check_reset_outputs("rst_rd");
        ARESET = 1'b0;
        bus.RREADY = 1'b0;
        tick();
        chk("rst_rd_awready", 32'(bus.AWREADY), 1);
        chk("rst_rd_arready", 32'(bus.ARREADY), 1);

        // Reset on beat 2 of an 8-beat write: beats 0-1 persist
        wait_aw();
        bus.AWADDR = 32'h300; bus.AWLEN = 4'd7; bus.AWSIZE = 3'd2; bus.AWBURST = 2'd1; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.WDATA = 32'hBEEF0000 + 32'(b); bus.WLAST = 1'b0; bus.WVALID = 1'b1;
            tick();
        end
        bus.WDATA = 32'hBEEF0002;
        ARESET = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        check_reset_outputs("rst_wr");
        ARESET = 1'b0;
        tick();
        chk("rst_wr_awready", 32'(bus.AWREADY), 1);
        chk("rst_wr_arready", 32'(bus.ARREADY), 1);
        exp_q.push_back(32'hBEEF0000);
        exp_q.push_back(32'hBEEF0001);
        read_burst(32'h300, 1, 3'd2, 2'd1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
